// File: rtl/result_argmax_if.sv
// rtl/result_argmax_if.sv - start/score/result bundle between the score stage and the argmax scanner
interface result_argmax_if #(
    parameter int N_CLASS = 46,
    parameter int DW      = 32,
    parameter int IDX_W   = 6
);
    logic                  start;
    logic [N_CLASS*DW-1:0] score_bus;
    logic                  busy;
    logic                  done;
    logic [IDX_W-1:0]      max_idx;
    logic [DW-1:0]         max_val;

    modport master (
        output start,
        output score_bus,
        input  busy,
        input  done,
        input  max_idx,
        input  max_val
    );

    modport slave (
        input  start,
        input  score_bus,
        output busy,
        output done,
        output max_idx,
        output max_val
    );
endinterface

// File: rtl/result_argmax.sv
// rtl/result_argmax.sv - snapshot a signed score bus and scan it one class per cycle for the maximum
module result_argmax #(
    parameter int N_CLASS = 46,
    parameter int DW      = 32,
    parameter int IDX_W   = 6
) (
    input  logic           clk,
    input  logic           rst,
    result_argmax_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    state_t                 state;
    logic signed [DW-1:0]   snap [N_CLASS];
    logic [IDX_W-1:0]       cnt;
    logic signed [DW-1:0]   best_val;
    logic [IDX_W-1:0]       best_idx;
    logic                   busy_r;
    logic                   done_r;
    logic [IDX_W-1:0]       max_idx_r;
    logic signed [DW-1:0]   max_val_r;

    logic signed [DW-1:0]   cand;
    logic                   cand_gt;

    // Candidate for this scan step; strict compare so ties keep the lower index.
    always_comb begin
        cand    = snap[cnt];
        cand_gt = (cand > best_val);
    end

    // Control FSM: snapshot on accept, one compare per SCAN cycle, publish result on DONE_ST entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            max_idx_r <= '0;
            max_val_r <= '0;
            for (int k = 0; k < N_CLASS; k++) begin
                snap[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE_ST: begin
                    if (bus.start) begin
                        // Upstream bus is free to change after this edge.
                        for (int k = 0; k < N_CLASS; k++) begin
                            snap[k] <= bus.score_bus[k*DW +: DW];
                        end
                        best_val <= bus.score_bus[DW-1:0];
                        best_idx <= '0;
                        cnt      <= IDX_W'(1);
                        busy_r   <= 1'b1;
                        state    <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (cand_gt) begin
                        best_val <= cand;
                        best_idx <= cnt;
                    end
                    if (cnt == LAST_IDX) begin
                        // Last class: fold its compare straight into the published result.
                        max_idx_r <= cand_gt ? cnt  : best_idx;
                        max_val_r <= cand_gt ? cand : best_val;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= DONE_ST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.max_idx = max_idx_r;
    assign bus.max_val = max_val_r;
endmodule

// File: tb/tb_result_argmax.sv
// tb/tb_result_argmax.sv - directed self-checking bench for result_argmax
module tb_result_argmax;
    localparam int N_CLASS = 46;
    localparam int DW      = 32;
    localparam int IDX_W   = 6;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    result_argmax_if #(.N_CLASS(N_CLASS), .DW(DW), .IDX_W(IDX_W)) intf ();

    result_argmax #(.N_CLASS(N_CLASS), .DW(DW), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int k = 0; k < N_CLASS; k++) intf.score_bus[k*DW +: DW] = v;
    endtask

    task automatic set_one(input int k, input logic [DW-1:0] v);
        intf.score_bus[k*DW +: DW] = v;
    endtask

    // Pulse start for one edge, then count negedges until done; bounded.
    task automatic do_scan(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (intf.busy) busy_n++;
            if (intf.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    int lat, busy_n, ndone, last_done;
    logic [IDX_W-1:0] got_idx [3];
    logic [DW-1:0]    got_val [3];
    int               gap     [3];

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        intf.start = 1'b0;
        set_all(32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_busy",    intf.busy,    1'b0);
        check("reset_done",    intf.done,    1'b0);
        check("reset_max_idx", intf.max_idx, 6'd0);
        check("reset_max_val", intf.max_val, 32'd0);

        // 1: all zero
        set_all(32'd0);
        do_scan(lat, busy_n);
        check("t1_latency",  lat,          46);
        check("t1_busy_len", busy_n,       45);
        check("t1_idx",      intf.max_idx, 6'd0);
        check("t1_val",      intf.max_val, 32'd0);
        @(negedge clk);
        check("t1_done_one_cycle", intf.done, 1'b0);
        check("t1_hold_idx",       intf.max_idx, 6'd0);

        // 2a: last class wins
        set_all(32'd99);
        set_one(45, 32'd100);
        do_scan(lat, busy_n);
        check("t2a_latency", lat,          46);
        check("t2a_idx",     intf.max_idx, 6'd45);
        check("t2a_val",     intf.max_val, 32'd100);

        // 2b: tie between 3 and 45 keeps lower index
        set_all(32'd5);
        set_one(3, 32'd100);
        set_one(45, 32'd100);
        do_scan(lat, busy_n);
        check("t2b_idx", intf.max_idx, 6'd3);
        check("t2b_val", intf.max_val, 32'd100);

        // 3: all negative, most-negative at class 0
        set_all(32'hFFFF_FC18);
        set_one(0, 32'h8000_0000);
        set_one(7, 32'hFFFF_FFFF);
        do_scan(lat, busy_n);
        check("t3_idx", intf.max_idx, 6'd7);
        check("t3_val", intf.max_val, 32'hFFFF_FFFF);

        // 4: bus changes after snapshot, start pulsed mid-scan
        set_all(32'd1);
        set_one(20, 32'd500);
        ndone = 0;
        lat   = 0;
        intf.start = 1'b1;
        @(negedge clk);
        set_all(32'h7FFF_FFFF);
        for (int k = 1; k <= 120; k++) begin
            intf.start = (k == 10);
            if (intf.done) begin
                ndone++;
                if (ndone == 1) begin
                    lat        = k;
                    got_idx[0] = intf.max_idx;
                    got_val[0] = intf.max_val;
                end
            end
            @(negedge clk);
        end
        intf.start = 1'b0;
        check("t4_done_count", ndone,      1);
        check("t4_latency",    lat,        46);
        check("t4_idx",        got_idx[0], 6'd20);
        check("t4_val",        got_val[0], 32'd500);

        // 5: reset mid-scan, then a clean scan
        set_all(32'd0);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        repeat (19) @(negedge clk);
        check("t5_busy_before_reset", intf.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy",    intf.busy,    1'b0);
        check("t5_rst_done",    intf.done,    1'b0);
        check("t5_rst_max_idx", intf.max_idx, 6'd0);
        check("t5_rst_max_val", intf.max_val, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_all(32'hFFFF_FFFB);
        set_one(33, 32'd42);
        do_scan(lat, busy_n);
        check("t5_latency", lat,          46);
        check("t5_idx",     intf.max_idx, 6'd33);
        check("t5_val",     intf.max_val, 32'd42);

        // 6: start held high, new bus after each done
        set_all(32'd0);
        set_one(11, 32'd77);
        ndone     = 0;
        last_done = 0;
        intf.start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 200; k++) begin
            if (intf.done && ndone < 3) begin
                got_idx[ndone] = intf.max_idx;
                got_val[ndone] = intf.max_val;
                gap[ndone]     = k - last_done;
                last_done      = k;
                ndone++;
                if (ndone == 1) begin
                    set_all(32'd8);
                    set_one(0, 32'd9);
                end else if (ndone == 2) begin
                    set_all(32'hFFFF_FFFD);
                    set_one(44, 32'hFFFF_FFFE);
                end else begin
                    intf.start = 1'b0;
                end
            end
            @(negedge clk);
        end
        intf.start = 1'b0;
        check("t6_done_count", ndone,      3);
        check("t6_first_lat",  gap[0],     46);
        check("t6_gap1",       gap[1],     46);
        check("t6_gap2",       gap[2],     46);
        check("t6_idx0",       got_idx[0], 6'd11);
        check("t6_val0",       got_val[0], 32'd77);
        check("t6_idx1",       got_idx[1], 6'd0);
        check("t6_val1",       got_val[1], 32'd9);
        check("t6_idx2",       got_idx[2], 6'd44);
        check("t6_val2",       got_val[2], 32'hFFFF_FFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
